// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types and constants for the memory arbiter
package core_pkg;

  typedef enum logic {SrcInst = 1'b0, SrcData = 1'b1} mem_src_e;

  localparam int Ilen     = 32;
  localparam int MemMaskW = Ilen / 8;

endpackage

// File: rtl/mem_tag_queue.sv
// rtl/mem_tag_queue.sv - circular queue of request source tags
module mem_tag_queue #(
  parameter int Width     = 1,
  parameter int DepthLog2 = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int Depth = 2 ** DepthLog2;

  logic [Width-1:0]     mem_q [Depth];
  logic [DepthLog2-1:0] wr_q;
  logic [DepthLog2-1:0] rd_q;
  logic [DepthLog2:0]   cnt_q;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (cnt_q == (DepthLog2 + 1)'(Depth));
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_q];
  // A push against a full queue is dropped even if a pop frees a slot this cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_data;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - merges instruction and data request ports onto one memory bus
module mem_arbiter
  import core_pkg::*;
#(
  parameter int Xlen      = 32,
  parameter int Ilen      = 32,
  parameter int DepthLog2 = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              inst_valid_i,
  output logic              inst_ready_o,
  input  logic [Xlen-1:0]   inst_addr_i,
  input  logic [Ilen-1:0]   inst_wdata_i,
  input  logic [Ilen/8-1:0] inst_wmask_i,
  output logic [Ilen-1:0]   inst_rdata_o,
  output logic              inst_rvalid_o,
  input  logic              data_valid_i,
  output logic              data_ready_o,
  input  logic [Xlen-1:0]   data_addr_i,
  input  logic [Ilen-1:0]   data_wdata_i,
  input  logic [Ilen/8-1:0] data_wmask_i,
  output logic [Ilen-1:0]   data_rdata_o,
  output logic              data_rvalid_o,
  input  logic              mem_ready_i,
  output logic              mem_valid_o,
  output logic [Xlen-1:0]   mem_addr_o,
  output logic [Ilen-1:0]   mem_wdata_o,
  output logic [Ilen/8-1:0] mem_wmask_o,
  input  logic [Ilen-1:0]   mem_rdata_i,
  input  logic              mem_rvalid_i
);

  mem_src_e grant;
  mem_src_e last_grant_q;
  mem_src_e lock_src_q;
  mem_src_e head;
  logic     head_raw;
  logic     lock_q;
  logic     err_q;
  logic     full;
  logic     empty;
  logic     req_valid;
  logic     accept;
  logic     pop;

  always_comb begin
    grant = SrcInst;
    if (lock_q)                          grant = lock_src_q;
    else if (inst_valid_i && data_valid_i) grant = (last_grant_q == SrcInst) ? SrcData : SrcInst;
    else if (data_valid_i)               grant = SrcData;
  end

  assign req_valid   = (inst_valid_i || data_valid_i) && !full;
  assign accept      = req_valid && mem_ready_i;
  assign mem_valid_o = rst_ni && req_valid;
  assign inst_ready_o = rst_ni && mem_ready_i && !full && (grant == SrcInst);
  assign data_ready_o = rst_ni && mem_ready_i && !full && (grant == SrcData);

  assign mem_addr_o  = (grant == SrcData) ? data_addr_i  : inst_addr_i;
  assign mem_wdata_o = (grant == SrcData) ? data_wdata_i : inst_wdata_i;
  assign mem_wmask_o = (grant == SrcData) ? data_wmask_i : inst_wmask_i;

  assign head          = mem_src_e'(head_raw);
  assign pop           = mem_rvalid_i && !empty;
  assign inst_rdata_o  = mem_rdata_i;
  assign data_rdata_o  = mem_rdata_i;
  assign inst_rvalid_o = rst_ni && pop && (head == SrcInst);
  assign data_rvalid_o = rst_ni && pop && (head == SrcData);

  mem_tag_queue #(
    .Width     (1),
    .DepthLog2 (DepthLog2)
  ) u_queue (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .push      (accept),
    .push_data (grant),
    .pop       (pop),
    .head      (head_raw),
    .full      (full),
    .empty     (empty)
  );

  // Hold the grant across a memory stall so the presented request never changes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q       <= 1'b0;
      lock_src_q   <= SrcInst;
      last_grant_q <= SrcInst;
      err_q        <= 1'b0;
    end else begin
      if (req_valid && !mem_ready_i) begin
        lock_q     <= 1'b1;
        lock_src_q <= grant;
      end else if (accept) begin
        lock_q <= 1'b0;
      end
      if (accept) last_grant_q <= grant;
      if (mem_rvalid_i && empty) err_q <= 1'b1;
    end
  end

  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(mem_rvalid_i && empty))
        else $warning("mem_arbiter: response with no outstanding request");
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_valid, inst_ready, inst_rvalid;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic [3:0]  inst_wmask;
  logic        data_valid, data_ready, data_rvalid;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_wmask;
  logic        mem_ready, mem_valid, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .inst_valid_i  (inst_valid),
    .inst_ready_o  (inst_ready),
    .inst_addr_i   (inst_addr),
    .inst_wdata_i  (inst_wdata),
    .inst_wmask_i  (inst_wmask),
    .inst_rdata_o  (inst_rdata),
    .inst_rvalid_o (inst_rvalid),
    .data_valid_i  (data_valid),
    .data_ready_o  (data_ready),
    .data_addr_i   (data_addr),
    .data_wdata_i  (data_wdata),
    .data_wmask_i  (data_wmask),
    .data_rdata_o  (data_rdata),
    .data_rvalid_o (data_rvalid),
    .mem_ready_i   (mem_ready),
    .mem_valid_o   (mem_valid),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_wmask_o   (mem_wmask),
    .mem_rdata_i   (mem_rdata),
    .mem_rvalid_i  (mem_rvalid)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    inst_valid = 1'b1; inst_addr = 32'h0; inst_wdata = 32'h0; inst_wmask = 4'h0;
    data_valid = 1'b1; data_addr = 32'h0; data_wdata = 32'h0; data_wmask = 4'h0;
    mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    tick();
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_inst_ready", inst_ready, 0);
    chk("rst_data_ready", data_ready, 0);
    chk("rst_err", dut.err_q, 0);
    inst_valid = 1'b0; data_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // single instruction read
    inst_valid = 1'b1; inst_addr = 32'h100;
    #1;
    chk("t1_addr", mem_addr, 32'h100);
    chk("t1_inst_ready", inst_ready, 1);
    chk("t1_data_ready", data_ready, 0);
    chk("t1_mem_valid", mem_valid, 1);
    tick();
    inst_valid = 1'b0;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    chk("t1_inst_rvalid", inst_rvalid, 1);
    chk("t1_data_rvalid", data_rvalid, 0);
    chk("t1_rdata", inst_rdata, 32'hDEADBEEF);
    tick();
    mem_rvalid = 1'b0;

    // tie: data wins, then inst
    inst_valid = 1'b1; inst_addr = 32'h0;
    data_valid = 1'b1; data_addr = 32'h2000; data_wmask = 4'hF; data_wdata = 32'h1234_5678;
    #1;
    chk("t2_addr_data", mem_addr, 32'h2000);
    chk("t2_data_ready", data_ready, 1);
    chk("t2_inst_ready", inst_ready, 0);
    chk("t2_wmask", mem_wmask, 4'hF);
    chk("t2_wdata", mem_wdata, 32'h1234_5678);
    tick();
    data_valid = 1'b0;
    #1;
    chk("t2_addr_inst", mem_addr, 32'h0);
    chk("t2_inst_ready2", inst_ready, 1);
    tick();
    inst_valid = 1'b0;
    mem_rvalid = 1'b1;
    #1;
    chk("t2_rsp1_data", data_rvalid, 1);
    chk("t2_rsp1_inst", inst_rvalid, 0);
    tick();
    chk("t2_rsp2_inst", inst_rvalid, 1);
    chk("t2_rsp2_data", data_rvalid, 0);
    tick();
    mem_rvalid = 1'b0;

    // stall lock: inst held while data appears
    mem_ready = 1'b0; inst_valid = 1'b1; inst_addr = 32'h300;
    #1;
    chk("t3_c1_addr", mem_addr, 32'h300);
    chk("t3_c1_valid", mem_valid, 1);
    chk("t3_c1_ready", inst_ready, 0);
    tick();
    data_valid = 1'b1; data_addr = 32'h4000;
    #1;
    chk("t3_c2_addr", mem_addr, 32'h300);
    chk("t3_c2_dready", data_ready, 0);
    tick();
    chk("t3_c3_addr", mem_addr, 32'h300);
    tick();
    mem_ready = 1'b1;
    #1;
    chk("t3_rel_iready", inst_ready, 1);
    chk("t3_rel_dready", data_ready, 0);
    chk("t3_rel_addr", mem_addr, 32'h300);
    tick();
    inst_valid = 1'b0;
    #1;
    chk("t3_data_ready", data_ready, 1);
    chk("t3_data_addr", mem_addr, 32'h4000);
    tick();
    data_valid = 1'b0;
    mem_rvalid = 1'b1;
    #1;
    chk("t3_rsp_inst", inst_rvalid, 1);
    tick();
    chk("t3_rsp_data", data_rvalid, 1);
    tick();
    mem_rvalid = 1'b0;

    // fill the tag queue
    inst_valid = 1'b1; inst_addr = 32'h500;
    for (int i = 0; i < 4; i++) tick();
    chk("t4_full_valid", mem_valid, 0);
    chk("t4_full_iready", inst_ready, 0);
    chk("t4_full_dready", data_ready, 0);
    mem_rvalid = 1'b1;
    #1;
    chk("t4_pop_iready", inst_ready, 0);
    chk("t4_pop_rvalid", inst_rvalid, 1);
    tick();
    mem_rvalid = 1'b0;
    #1;
    chk("t4_after_iready", inst_ready, 1);
    chk("t4_after_valid", mem_valid, 1);
    tick();
    inst_valid = 1'b0;
    #1;
    chk("t4_refull_valid", mem_valid, 0);
    inst_valid = 1'b1;
    #1;
    chk("t4_refull_iready", inst_ready, 0);
    inst_valid = 1'b0;
    mem_rvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t4_drain", inst_rvalid, 1);
      tick();
    end
    mem_rvalid = 1'b0;

    // response with empty queue
    mem_rvalid = 1'b1;
    #1;
    chk("t5_inst_rvalid", inst_rvalid, 0);
    chk("t5_data_rvalid", data_rvalid, 0);
    tick();
    mem_rvalid = 1'b0;
    chk("t5_err", dut.err_q, 1);

    // async reset mid-stall with two outstanding
    data_valid = 1'b1; data_addr = 32'h6000;
    tick();
    tick();
    data_valid = 1'b0;
    mem_ready = 1'b0; inst_valid = 1'b1; inst_addr = 32'h700;
    tick();
    #2;
    rst_n = 1'b0;
    mem_rvalid = 1'b1;
    #1;
    chk("t6_rst_valid", mem_valid, 0);
    chk("t6_rst_iready", inst_ready, 0);
    chk("t6_rst_dready", data_ready, 0);
    chk("t6_rst_irvalid", inst_rvalid, 0);
    chk("t6_rst_drvalid", data_rvalid, 0);
    chk("t6_rst_err", dut.err_q, 0);
    mem_rvalid = 1'b0;
    tick();
    rst_n = 1'b1;
    mem_ready = 1'b1; inst_valid = 1'b1; data_valid = 1'b1;
    #1;
    chk("t6_empty", dut.empty, 1);
    chk("t6_tie_data", data_ready, 1);
    chk("t6_tie_inst", inst_ready, 0);
    chk("t6_tie_addr", mem_addr, 32'h6000);
    tick();
    inst_valid = 1'b0; data_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
